lsu_dmem_ctrl: RTL and testbench

//  Load/store controller directly upstream of DMEM (1024 x 32b, sync write, registered read).

---
 rtl/lsu_pkg.sv | 76 +++++++
 rtl/lsu_align.sv | 24 ++
 rtl/lsu_dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store controller.
//   SZ_BYTE/SZ_HALF/SZ_WORD : request size encodings (2'b11 is treated as word)
//   lsu_state_t             : controller FSM states
//   norm_size               : folds the 2'b11 size encoding onto SZ_WORD
//   is_misaligned           : half with addr[0]=1, or word with addr[1:0]!=0
//   force_align             : clears the low address bits to the natural alignment
//   lane_extract            : picks a little-endian lane, then sign/zero-extends it
//   lane_merge              : replaces only the target lane(s) of an old word
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_CAPT,
      ST_WRITE,
      ST_RESP
   } lsu_state_t;

   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == 2'b11) ? SZ_WORD : sz;
   endfunction

   // sz must already be normalised
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return a[0];
         default: return |a;
      endcase
   endfunction

   function automatic logic [1:0] force_align(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: return a;
         SZ_HALF: return {a[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  a,
                                                input logic [1:0]  sz,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{a, 3'b000} +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  a,
                                              input logic [1:0]  sz);
      logic [31:0] w;
      w = old;
      case (sz)
         SZ_BYTE: w[{a, 3'b000} +: 8] = wd[7:0];
         SZ_HALF: begin
            if (a[1]) w[31:16] = wd[15:0];
            else      w[15:0]  = wd[15:0];
         end
         default: w = wd;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store controller.
//   word_i     : word read from DMEM
//   addr_lo_i  : byte offset within the word (already aligned for the size)
//   size_i     : normalised access size
//   unsigned_i : 1 = zero-extend loads, 0 = sign-extend
//   wdata_i    : right-justified store data
//   ld_data_o  : extracted and extended load result
//   st_word_o  : word_i with the target lane(s) replaced by wdata_i
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   assign ld_data_o = lane_extract(word_i, addr_lo_i, size_i, unsigned_i);
   assign st_word_o = lane_merge(word_i, wdata_i, addr_lo_i, size_i);

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: byte/half/word load-store controller in front of a DMEM with
// no byte enables (sync write, registered read). Sub-word stores are done as
// read-modify-write.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   resp_valid, resp_rdata, resp_err : one-cycle completion, no backpressure
//   daddr, we, indata          : DMEM word address (byte form), write enable, data
//   outdata                    : DMEM read data, one cycle after daddr
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned accesses skip
// DMEM and complete immediately with resp_err=1; otherwise the low address bits
// are forced to natural alignment and resp_err is always 0.
module lsu_dmem_ctrl
   import lsu_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int DMEM_DEPTH = 1024
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          resp_err,
   output logic [AW-1:0] daddr,
   output logic          we,
   output logic [DW-1:0] indata,
   input  logic [DW-1:0] outdata
);

   if (DW != 32 || DMEM_DEPTH < 1) begin : g_bad_cfg
      $error("lsu_dmem_ctrl supports DW=32 only");
   end

   lsu_state_t    state_q, state_d;
   logic [AW-1:0] addr_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic          st_q;
   logic [DW-1:0] data_q;   // store word: raw wdata, then merged word for RMW
   logic [DW-1:0] rdata_q;

   logic          acc;
   logic [1:0]    sz_n;
   logic [DW-1:0] ld_data, st_word;

   assign acc  = req_valid && (state_q == ST_IDLE);
   assign sz_n = norm_size(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
   logic misal;
   logic err_q;
   assign misal = is_misaligned(sz_n, req_addr[1:0]);
`endif

   lsu_align u_align (
      .word_i     (outdata),
      .addr_lo_i  (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .wdata_i    (data_q),
      .ld_data_o  (ld_data),
      .st_word_o  (st_word)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
               if (misal)                               state_d = ST_RESP;
               else
`endif
               if (req_we && sz_n == SZ_WORD)           state_d = ST_WRITE;
               else                                     state_d = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_CAPT;
         ST_RD_CAPT:  state_d = st_q ? ST_WRITE : ST_RESP;
         ST_WRITE:    state_d = ST_RESP;
         ST_RESP:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // outputs: decoded from state so reset drops we in the same cycle
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      we         = (state_q == ST_WRITE);
      resp_valid = (state_q == ST_RESP);
      daddr      = {addr_q[AW-1:2], 2'b00};
      indata     = data_q;
      resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err   = err_q;
`else
      resp_err   = 1'b0;
`endif
   end

   // request latch and datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         size_q  <= SZ_WORD;
         uns_q   <= 1'b0;
         st_q    <= 1'b0;
         data_q  <= '0;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else if (acc) begin
         size_q  <= sz_n;
         uns_q   <= req_unsigned;
         st_q    <= req_we;
         data_q  <= req_wdata;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         addr_q  <= req_addr;
         err_q   <= misal;
`else
         addr_q  <= {req_addr[AW-1:2], force_align(sz_n, req_addr[1:0])};
`endif
      end else if (state_q == ST_RD_CAPT) begin
         if (st_q) data_q  <= st_word;
         else      rdata_q <= ld_data;
      end
   end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb_lsu_dmem_ctrl: directed scoreboard bench for lsu_dmem_ctrl with a
// behavioural DMEM (1024 x 32, sync write, registered read). Stimulus pushes
// the expected response; a negedge monitor pops and compares rdata, err and
// accept-to-response latency.
module tb_lsu_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, we;
   logic [31:0] resp_rdata, daddr, indata, outdata;

   always #5 clk = ~clk;

   lsu_dmem_ctrl #(.AW(32), .DW(32), .DMEM_DEPTH(1024)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .daddr(daddr), .we(we), .indata(indata),
      .outdata(outdata)
   );

   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (we) mem[daddr[11:2]] <= indata;
      outdata <= mem[daddr[11:2]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int we_cnt = 0;
   always @(negedge clk) if (we) we_cnt++;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      string       name;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h want %08h", nm, act, exp);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      exp_t e;
      if (!reset && resp_valid) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got rdata %08h with no pending request", resp_rdata);
         end else begin
            e = sb.pop_front();
            chk({e.name, " rdata"}, resp_rdata, e.rdata);
            chk({e.name, " err"}, {31'h0, resp_err}, {31'h0, e.err});
            chk({e.name, " latency"}, 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   task automatic issue(input string nm, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int lat);
      exp_t e;
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL %s accept_timeout: ready stayed 0, want 1", nm);
      end else begin
         e.rdata = erd; e.err = eerr; e.lat = lat; e.acc = cyc; e.name = nm;
         sb.push_back(e);
         @(posedge clk);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b0;
      while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain pending", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'h5A000000 ^ (32'(i) * 32'h00010003);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst req_ready",  {31'h0, req_ready},  32'd1);
      chk("rst resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("rst resp_err",   {31'h0, resp_err},   32'd0);
      chk("rst resp_rdata", resp_rdata,          32'd0);
      chk("rst we",         {31'h0, we},         32'd0);
      chk("rst daddr",      daddr,               32'd0);
      chk("rst indata",     indata,              32'd0);
      @(negedge clk); reset = 1'b0;

      // word store/load
      wc = we_cnt;
      issue("SW 0x10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
      drain();
      chk("SW single we pulse", 32'(we_cnt - wc), 32'd1);
      issue("LW 0x10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3);
      issue("LW size11 0x10", 0, 2'b11, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3);
      drain();

      // byte read-modify-write
      issue("SW 0x10 b", 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 2);
      issue("SB 0x13",   1, 2'b00, 0, 32'h13, 32'hFFFFFF80, 32'h0, 0, 4);
      issue("LW after SB", 0, 2'b10, 0, 32'h10, 32'h0, 32'h80223344, 0, 3);
      issue("LB 0x13",   0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 3);
      issue("LBU 0x13",  0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 3);
      issue("LB 0x10",   0, 2'b00, 0, 32'h10, 32'h0, 32'h00000044, 0, 3);
      drain();

      // half read-modify-write
      issue("SW 0x10 h", 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 2);
      issue("SH 0x12",   1, 2'b01, 0, 32'h12, 32'h0000ABCD, 32'h0, 0, 4);
      issue("LW after SH", 0, 2'b10, 0, 32'h10, 32'h0, 32'hABCD3344, 0, 3);
      issue("LH 0x12",   0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFABCD, 0, 3);
      issue("LHU 0x10",  0, 2'b01, 1, 32'h10, 32'h0, 32'h00003344, 0, 3);
      drain();

      // misaligned accesses never write
      wc = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
      issue("LW 0x11 mis", 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, 1);
      issue("LH 0x11 mis", 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 1);
`else
      issue("LW 0x11 mis", 0, 2'b10, 0, 32'h11, 32'h0, 32'hABCD3344, 0, 3);
      issue("LH 0x11 mis", 0, 2'b01, 0, 32'h11, 32'h0, 32'h00003344, 0, 3);
`endif
      drain();
      chk("misaligned no we", 32'(we_cnt - wc), 32'd0);

      // reset during the write phase of a byte store
      issue("SW 0x20", 1, 2'b10, 0, 32'h20, 32'h55667788, 32'h0, 0, 2);
      drain();
      issue("SB 0x21 aborted", 1, 2'b00, 0, 32'h21, 32'h000000AA, 32'h0, 0, 4);
      begin
         int n;
         n = 0;
         while (!we && n < 20) begin @(negedge clk); n++; end
         chk("SB reached WRITE", {31'h0, we}, 32'd1);
      end
      #1 reset = 1'b1; req_valid = 1'b0;
      #1 chk("we drops on reset", {31'h0, we}, 32'd0);
      void'(sb.pop_back());
      @(negedge clk); reset = 1'b0;
      #1 chk("ready after reset", {31'h0, req_ready}, 32'd1);
      issue("LW 0x20 after abort", 0, 2'b10, 0, 32'h20, 32'h0, 32'h55667788, 0, 3);
      drain();

      // back-to-back sweep across the whole DMEM, then aliasing
      for (int i = 0; i < 1024; i++)
         issue("SW sweep", 1, 2'b10, 0, 32'(i * 4), pat(i), 32'h0, 0, 2);
      for (int i = 0; i < 1024; i++)
         issue("LW sweep", 0, 2'b10, 0, 32'(i * 4), 32'h0, pat(i), 0, 3);
      issue("SW 0x1000 alias", 1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, 32'h0, 0, 2);
      issue("LW 0x0 alias",    0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 3);
      issue("LW 0x4 intact",   0, 2'b10, 0, 32'h4, 32'h0, pat(1), 0, 3);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
